led_row_scan_ctrl: RTL

Row-scan sequencer for an 8-row LED/display matrix. It drives the 3-bit row address and active-low enable of the downstream 3-to-8 active-low row decoder, and presents the matching column pattern. Frame data lives in a double-buffered 8-row store. The host writes the back bank and requests a swap; the swap is applied only at a frame boundary, so no frame is ever shown torn. Each row change is preceded by a blanking interval (decoder disabled) to suppress ghosting.

---
 rtl/led_scan_pkg.sv | 16 +
 rtl/scan_fbuf.sv | 41 ++++
 rtl/led_row_scan_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared row-scan types and constants: row count, row address width, scan FSM states.
// Pure declarations; no timing or flow control.
package led_scan_pkg;
  localparam int ROWS   = 8;
  localparam int ROW_AW = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ON
  } state_t;

  function automatic logic [ROW_AW-1:0] next_row(input logic [ROW_AW-1:0] row);
    return row + 1'b1;
  endfunction
endpackage

// File: rtl/scan_fbuf.sv
// Double-buffered ROWS x COLS frame store: write port into back bank, combinational read.
// Zero-latency read; the write lands on the clock edge; no backpressure.
module scan_fbuf
  import led_scan_pkg::*;
#(
  parameter int COLS = 8
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_wr_en,
  input  logic [ROW_AW-1:0] i_wr_row,
  input  logic [COLS-1:0]   i_wr_data,
  input  logic              i_swap,
  input  logic [ROW_AW-1:0] i_rd_row,
  input  logic              i_rd_next,
  output logic [COLS-1:0]   o_rd_data
);
  logic [COLS-1:0] r_bank [2][ROWS];
  logic            r_front;
  logic            w_rd_bank;
  logic            w_fwd;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_front <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          r_bank[b][r] <= '0;
        end
      end
    end else begin
      if (i_wr_en) r_bank[~r_front][i_wr_row] <= i_wr_data;
      if (i_swap)  r_front <= ~r_front;
    end
  end

  // i_rd_next reads the bank that becomes front on this edge, including a write landing now.
  assign w_rd_bank = i_rd_next ? ~r_front : r_front;
  assign w_fwd     = i_rd_next && i_wr_en && (i_wr_row == i_rd_row);
  assign o_rd_data = w_fwd ? i_wr_data : r_bank[w_rd_bank][i_rd_row];
endmodule

// File: rtl/led_row_scan_ctrl.sv
// Row-scan sequencer: BLANK-cycle blanking then DWELL-cycle lit period per row, 8 rows/frame.
// All outputs registered; bank swaps deferred to the frame boundary; no backpressure.
module led_row_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int COLS  = 8,
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_en,
  input  logic              i_wr_en,
  input  logic [ROW_AW-1:0] i_wr_row,
  input  logic [COLS-1:0]   i_wr_data,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic [ROW_AW-1:0] o_addr,
  output logic              o_nen,
  output logic [COLS-1:0]   o_col_data,
  output logic              o_frame_done
);
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [ROW_AW-1:0] r_addr, w_addr_nxt;
  logic              r_nen, w_nen_nxt;
  logic [COLS-1:0]   r_col, w_col_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_swap_ack, w_swap_ack_nxt;
  logic              r_swap_armed, w_swap_armed_nxt;
  logic              w_swap;
  logic [ROW_AW-1:0] w_rd_row;
  logic              w_rd_next;
  logic [COLS-1:0]   w_rd_data;

  scan_fbuf #(.COLS(COLS)) u_fbuf (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .i_wr_en   (i_wr_en),
    .i_wr_row  (i_wr_row),
    .i_wr_data (i_wr_data),
    .i_swap    (w_swap),
    .i_rd_row  (w_rd_row),
    .i_rd_next (w_rd_next),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_nen        <= 1'b1;
      r_col        <= '0;
      r_frame_done <= 1'b0;
      r_swap_ack   <= 1'b0;
      r_swap_armed <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_nen        <= w_nen_nxt;
      r_col        <= w_col_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_swap_ack   <= w_swap_ack_nxt;
      r_swap_armed <= w_swap_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_addr_nxt       = r_addr;
    w_nen_nxt        = 1'b1;
    w_col_nxt        = r_col;
    w_frame_done_nxt = 1'b0;
    w_swap_ack_nxt   = 1'b0;
    w_swap           = 1'b0;
    w_rd_row         = r_addr;
    w_rd_next        = 1'b0;

    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_addr_nxt  = '0;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = BLANK_LD;
          w_addr_nxt  = '0;
          w_rd_row    = '0;
          w_col_nxt   = w_rd_data;
        end
        ST_BLANK: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = DWELL_LD;
            w_nen_nxt   = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt - 1'b1;
          end
        end
        ST_ON: begin
          w_nen_nxt = 1'b0;
          if (r_cnt == '0) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = BLANK_LD;
            w_nen_nxt   = 1'b1;
            w_rd_row    = next_row(r_addr);
            w_addr_nxt  = w_rd_row;
            // Frame boundary: the only place a pending swap may take effect.
            if (r_addr == ROW_AW'(ROWS - 1)) begin
              w_frame_done_nxt = 1'b1;
              if (i_swap_req && r_swap_armed) begin
                w_swap         = 1'b1;
                w_swap_ack_nxt = 1'b1;
                w_rd_next      = 1'b1;
              end
            end
            w_col_nxt = w_rd_data;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_addr_nxt  = '0;
          w_col_nxt   = '0;
        end
      endcase
    end
  end

  // A request that was acked must be seen low once before it can swap again.
  always_comb begin
    w_swap_armed_nxt = r_swap_armed;
    if (w_swap)          w_swap_armed_nxt = 1'b0;
    else if (!i_swap_req) w_swap_armed_nxt = 1'b1;
  end

  assign o_swap_ack   = r_swap_ack;
  assign o_addr       = r_addr;
  assign o_nen        = r_nen;
  assign o_col_data   = r_col;
  assign o_frame_done = r_frame_done;
endmodule
